// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit for the execute stage.
// Handles MULTU/MULT/DIVU/DIV one bit per cycle: shift-add multiply, restoring divide.
// Produces a 2*WIDTH {hi,lo} result for the HILO path.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     srca,
    input  logic [WIDTH-1:0]     srcb,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]      count;
    logic               is_div;
    logic               sign_q;
    logic               sign_r;
    logic               dz;
    logic [WIDTH-1:0]   operand;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH-1:0] acc;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] acc_step;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // The pipeline stalls while a request is pending and the result is not yet out.
    assign stall = start & ~done;

    // Operand magnitudes; only the signed ops (op[0]=1) look at the MSB.
    always_comb begin
        a_neg = op[0] & srca[WIDTH-1];
        b_neg = op[0] & srcb[WIDTH-1];
        a_mag = a_neg ? -srca : srca;
        b_mag = b_neg ? -srcb : srcb;
    end

    // Next-state logic; flush returns to IDLE from anywhere and blocks acceptance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // State register plus registered busy/done derived from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == CALC) || (state_next == FIX);
            done  <= (state_next == DONE);
        end
    end

    // One iteration step. The multiply keeps the W+1-bit partial sum carry in the
    // top bit of the already-shifted accumulator, so 2*WIDTH bits of state suffice.
    // For divide the accumulator holds {remainder, quotient/dividend}.
    always_comb begin
        mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        trial     = rem_shift - {1'b0, operand};
        acc_step  = acc;
        if (is_div) begin
            if (!trial[WIDTH]) begin
                acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_step = {mult_sum, acc[WIDTH-1:1]};
            end else begin
                acc_step = {1'b0, acc[2*WIDTH-1:1]};
            end
        end
    end

    // Sign correction applied once the magnitude result is complete.
    always_comb begin
        prod_fix = sign_q ? -acc : acc;
        quot_fix = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Datapath: latch operands on accept, iterate in CALC, publish the result in FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            is_div   <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz       <= 1'b0;
            operand  <= '0;
            a_raw    <= '0;
            acc      <= '0;
            result   <= '0;
            div_zero <= 1'b0;
        end else if (state == IDLE && state_next == CALC) begin
            is_div <= op[1];
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            dz     <= op[1] & (srcb == '0);
            a_raw  <= srca;
            count  <= CW'(WIDTH - 1);
            if (op[1]) begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                operand <= b_mag;
            end else begin
                acc     <= {{WIDTH{1'b0}}, b_mag};
                operand <= a_mag;
            end
        end else if (state == CALC && !flush) begin
            acc   <= acc_step;
            count <= count - CW'(1);
        end else if (state == FIX && state_next == DONE) begin
            if (!is_div) begin
                result   <= prod_fix;
                div_zero <= 1'b0;
            end else if (dz) begin
                result   <= {a_raw, {WIDTH{1'b1}}};
                div_zero <= 1'b1;
            end else begin
                result   <= {rem_fix, quot_fix};
                div_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed testbench for muldiv_iter with a 32-bit and an 8-bit instance.
module tb_muldiv_iter;

    logic        clk;
    logic        reset;
    logic        flush;

    logic        start32;
    logic [1:0]  op32;
    logic [31:0] srca32;
    logic [31:0] srcb32;
    logic        stall32;
    logic        busy32;
    logic        done32;
    logic [63:0] result32;
    logic        div_zero32;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  srca8;
    logic [7:0]  srcb8;
    logic        stall8;
    logic        busy8;
    logic        done8;
    logic [15:0] result8;
    logic        div_zero8;

    int checks = 0;
    int errors = 0;

    muldiv_iter #(.WIDTH(32)) dut32 (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .start    (start32),
        .op       (op32),
        .srca     (srca32),
        .srcb     (srcb32),
        .stall    (stall32),
        .busy     (busy32),
        .done     (done32),
        .result   (result32),
        .div_zero (div_zero32)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .start    (start8),
        .op       (op8),
        .srca     (srca8),
        .srcb     (srcb8),
        .stall    (stall8),
        .busy     (busy8),
        .done     (done8),
        .result   (result8),
        .div_zero (div_zero8)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request to the 32-bit instance and hold start.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op32    = o;
        srca32  = a;
        srcb32  = b;
        start32 = 1'b1;
    endtask

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Full operation on the 32-bit instance: accept, wait for done, check, release.
    task automatic runOp32(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_result, input logic exp_dz);
        int n;
        applyStimulus(o, a, b);
        @(posedge clk); #1;
        checkOutput({tag, " busy_calc"}, {63'b0, busy32}, 64'd1);
        checkOutput({tag, " stall_calc"}, {63'b0, stall32}, 64'd1);
        n = 0;
        while (!done32 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        // Done appears after edge k+WIDTH+1 when accepted at edge k.
        checkOutput({tag, " latency"}, 64'(n), 64'd33);
        checkOutput({tag, " result"}, result32, exp_result);
        checkOutput({tag, " div_zero"}, {63'b0, div_zero32}, {63'b0, exp_dz});
        checkOutput({tag, " stall_done"}, {63'b0, stall32}, 64'd0);
        checkOutput({tag, " busy_done"}, {63'b0, busy32}, 64'd0);
        start32 = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, " done_pulse"}, {63'b0, done32}, 64'd0);
    endtask

    initial begin
        int pulses;
        int first;
        int second;
        logic [15:0] r1;
        logic [15:0] r2;

        reset   = 1'b1;
        flush   = 1'b0;
        start32 = 1'b0;
        op32    = 2'b00;
        srca32  = '0;
        srcb32  = '0;
        start8  = 1'b0;
        op8     = 2'b00;
        srca8   = '0;
        srcb8   = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset result", result32, 64'd0);
        checkOutput("reset busy", {63'b0, busy32}, 64'd0);
        checkOutput("reset done", {63'b0, done32}, 64'd0);
        checkOutput("reset div_zero", {63'b0, div_zero32}, 64'd0);
        checkOutput("reset stall", {63'b0, stall32}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        runOp32("multu 7*6", 2'b00, 32'd7, 32'd6, 64'h00000000_0000002A, 1'b0);
        runOp32("mult -3*5", 2'b01, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b0);
        runOp32("mult minneg^2", 2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
        runOp32("div -7/2", 2'b11, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        runOp32("divu 100/7", 2'b10, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);

        // Flush at CALC step 10: no done, result retained.
        applyStimulus(2'b11, 32'hFFFFFFF9, 32'd2);
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        flush   = 1'b1;
        start32 = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush busy", {63'b0, busy32}, 64'd0);
        checkOutput("flush done", {63'b0, done32}, 64'd0);
        checkOutput("flush result", result32, 64'h00000002_0000000E);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32) pulses++;
        end
        checkOutput("flush no_done", 64'(pulses), 64'd0);
        checkOutput("flush result_hold", result32, 64'h00000002_0000000E);
        runOp32("div after flush", 2'b11, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);

        // Start coincident with flush in IDLE is not accepted.
        applyStimulus(2'b10, 32'd100, 32'd7);
        flush = 1'b1;
        @(posedge clk); #1;
        checkOutput("coincident busy", {63'b0, busy32}, 64'd0);
        flush   = 1'b0;
        start32 = 1'b0;
        @(posedge clk); #1;
        checkOutput("coincident idle", {63'b0, busy32}, 64'd0);

        runOp32("divu by zero", 2'b10, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 1'b1);
        runOp32("div by zero", 2'b11, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1);

        // Reset in the middle of CALC clears every output.
        applyStimulus(2'b00, 32'd7, 32'd6);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        reset   = 1'b1;
        start32 = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset result", result32, 64'd0);
        checkOutput("midreset busy", {63'b0, busy32}, 64'd0);
        checkOutput("midreset done", {63'b0, done32}, 64'd0);
        checkOutput("midreset div_zero", {63'b0, div_zero32}, 64'd0);
        checkOutput("midreset stall", {63'b0, stall32}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // WIDTH=8: MULT 0x80*0xFF then DIV 0x80/0xFF back to back with start held.
        op8    = 2'b01;
        srca8  = 8'h80;
        srcb8  = 8'hFF;
        start8 = 1'b1;
        first  = -1;
        second = -1;
        pulses = 0;
        r1     = '0;
        r2     = '0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                op8   = 2'b11;
                srca8 = 8'h80;
                srcb8 = 8'hFF;
            end
            if (done8) begin
                pulses++;
                if (first < 0) begin
                    first = e;
                    r1    = result8;
                end else if (second < 0) begin
                    second = e;
                    r2     = result8;
                    start8 = 1'b0;
                end
            end
        end
        checkOutput("w8 first_done", 64'(first), 64'd9);
        checkOutput("w8 spacing", 64'(second - first), 64'd11);
        checkOutput("w8 pulses", 64'(pulses), 64'd2);
        checkOutput("w8 mult", {48'b0, r1}, 64'h0080);
        checkOutput("w8 div", {48'b0, r2}, 64'h0080);
        checkOutput("w8 div_zero", {63'b0, div_zero8}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
